// File: rtl/ringbuf_array.sv
// Per-channel sample ring buffers serving FIR tap fetches, with one-cycle registered tap reads.
// Optional build macro RINGBUF_ZERO_FILL_EN: taps beyond the current level read as zero.
module ringbuf_array #(
  parameter int NUM_CH     = 8,
  parameter int OFFSET_W   = 5,
  parameter int DEPTH_LOG2 = 6,
  parameter int DW         = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              push_i,
  input  logic [DW*NUM_CH-1:0]           push_data_i,
  input  logic [NUM_CH-1:0]              pop_i,
  input  logic [OFFSET_W*NUM_CH-1:0]     offset_i,
  output logic [DW*NUM_CH-1:0]           data_o,
  output logic [NUM_CH-1:0]              valid_o,
  output logic [(DEPTH_LOG2+1)*NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0]              full_o,
  output logic [NUM_CH-1:0]              empty_o,
  output logic [NUM_CH-1:0]              ovf_o,
  output logic [NUM_CH-1:0]              udf_o,
  input  logic                           clr_err_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrptr;
    logic [DEPTH_LOG2-1:0] rdptr;
    logic [DEPTH_LOG2-1:0] addr;
    logic [LW-1:0]         level;
    logic [OFFSET_W-1:0]   offset;
    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  tap_ok;
    logic [DW-1:0]         data_p1;
    logic                  vld_p1;
    logic                  ovf;
    logic                  udf;

    // Full/empty are judged on the pre-update level, so a push at full is
    // dropped even when a pop in the same cycle frees a slot.
    assign offset  = offset_i[OFFSET_W*ch +: OFFSET_W];
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push_i[ch] & ~full;
    assign pop_ok  = pop_i[ch] & ~empty;
    assign addr    = rdptr + DEPTH_LOG2'(offset);
    assign tap_ok  = (LW'(offset) < level);

    always_ff @(posedge clk) begin
      if (push_ok) begin
        mem[wrptr] <= push_data_i[DW*ch +: DW];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wrptr <= '0;
        rdptr <= '0;
        level <= '0;
        ovf   <= 1'b0;
        udf   <= 1'b0;
      end else begin
        if (push_ok) wrptr <= wrptr + DEPTH_LOG2'(1);
        if (pop_ok)  rdptr <= rdptr + DEPTH_LOG2'(1);
        case ({push_ok, pop_ok})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
        ovf <= (push_i[ch] & full)  | (ovf & ~clr_err_i);
        udf <= (pop_i[ch]  & empty) | (udf & ~clr_err_i);
      end
    end

    // ---- stage p1: registered tap read (old content on same-cycle write) ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_p1 <= '0;
        vld_p1  <= 1'b0;
      end else begin
`ifdef RINGBUF_ZERO_FILL_EN
        data_p1 <= tap_ok ? mem[addr] : '0;
`else
        data_p1 <= mem[addr];
`endif
        vld_p1  <= tap_ok;
      end
    end

    assign data_o[DW*ch +: DW]  = data_p1;
    assign valid_o[ch]          = vld_p1;
    assign level_o[LW*ch +: LW] = level;
    assign full_o[ch]           = full;
    assign empty_o[ch]          = empty;
    assign ovf_o[ch]            = ovf;
    assign udf_o[ch]            = udf;
  end

endmodule

// File: tb/tb_ringbuf_array.sv
// Directed self-checking bench for ringbuf_array: fill/read, overflow, underflow,
// error clear, pointer wrap, read-before-write and asynchronous reset.
module tb_ringbuf_array;

  localparam int NUM_CH     = 8;
  localparam int OFFSET_W   = 5;
  localparam int DEPTH_LOG2 = 6;
  localparam int DW         = 24;
  localparam int LW         = DEPTH_LOG2 + 1;

  logic                       clk;
  logic                       rst;
  logic [NUM_CH-1:0]          push_i;
  logic [DW*NUM_CH-1:0]       push_data_i;
  logic [NUM_CH-1:0]          pop_i;
  logic [OFFSET_W*NUM_CH-1:0] offset_i;
  logic [DW*NUM_CH-1:0]       data_o;
  logic [NUM_CH-1:0]          valid_o;
  logic [LW*NUM_CH-1:0]       level_o;
  logic [NUM_CH-1:0]          full_o;
  logic [NUM_CH-1:0]          empty_o;
  logic [NUM_CH-1:0]          ovf_o;
  logic [NUM_CH-1:0]          udf_o;
  logic                       clr_err_i;

  int n_checks;
  int n_errors;

  ringbuf_array #(
    .NUM_CH(NUM_CH), .OFFSET_W(OFFSET_W), .DEPTH_LOG2(DEPTH_LOG2), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .push_i(push_i), .push_data_i(push_data_i), .pop_i(pop_i), .offset_i(offset_i),
    .data_o(data_o), .valid_o(valid_o), .level_o(level_o),
    .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o), .udf_o(udf_o),
    .clr_err_i(clr_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lvl(input int ch);
    return 32'(level_o[LW*ch +: LW]);
  endfunction

  function automatic logic [31:0] dat(input int ch);
    return 32'(data_o[DW*ch +: DW]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    push_data_i[DW*ch +: DW] = v;
  endtask

  task automatic set_off(input int ch, input logic [OFFSET_W-1:0] v);
    offset_i[OFFSET_W*ch +: OFFSET_W] = v;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"}, 32'(level_o), 32'd0);
    check({tag, "_empty"}, 32'(empty_o), 32'hFF);
    check({tag, "_full"},  32'(full_o),  32'h00);
    check({tag, "_valid"}, 32'(valid_o), 32'h00);
    check({tag, "_data0"}, dat(0),       32'h0);
    check({tag, "_ovf"},   32'(ovf_o),   32'h00);
    check({tag, "_udf"},   32'(udf_o),   32'h00);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    push_i      = '0;
    push_data_i = '0;
    pop_i       = '0;
    offset_i    = '0;
    clr_err_i   = 1'b0;

    #12 rst = 1'b0;
    #1;
    check_reset_state("rst");

    // Fill ch0 with 1..4
    push_i = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      set_data(0, 24'(i));
      step();
    end
    push_i = '0;
    check("fill_level0", lvl(0), 32'd4);
    check("fill_empty",  32'(empty_o), 32'hFE);
    check("fill_full",   32'(full_o),  32'h00);

    // Tap read at offset 2, then beyond level
    set_off(0, 5'd2);
    step();
    check("tap2_data",  dat(0), 32'h000003);
    check("tap2_valid", 32'(valid_o), 32'h01);
    set_off(0, 5'd4);
    step();
    check("tap4_valid", 32'(valid_o[0]), 32'd0);
`ifdef RINGBUF_ZERO_FILL_EN
    check("tap4_zero",  dat(0), 32'h0);
`endif
    set_off(0, 5'd0);

    // Fill ch3 to full, then overflow
    push_i = 8'h08;
    for (int i = 0; i < 64; i++) begin
      set_data(3, 24'h300000 + 24'(i));
      step();
    end
    check("full_level3", lvl(3), 32'd64);
    check("full_flag3",  32'(full_o[3]), 32'd1);
    check("full_ovf_pre", 32'(ovf_o), 32'h00);
    set_data(3, 24'hABCDEF);
    step();
    check("ovf_set",    32'(ovf_o), 32'h08);
    check("ovf_level3", lvl(3), 32'd64);
    pop_i = 8'h08;
    step();
    push_i = '0;
    pop_i  = '0;
    check("pushpop_full_level", lvl(3), 32'd63);
    check("pushpop_full_ovf",   32'(ovf_o[3]), 32'd1);
    check("pushpop_full_tap0",  dat(3), 32'h300000);
    // Newest stored sample sits at offset 62 from the oldest; only offsets up
    // to 31 are reachable, so verify the dropped word never reached the head.
    set_off(3, 5'd31);
    step();
    check("ch3_tap31", dat(3), 32'h300020);
    set_off(3, 5'd0);

    // Underflow and sticky clear
    pop_i = 8'h20;
    step();
    pop_i = '0;
    check("udf_set",    32'(udf_o), 32'h20);
    check("udf_level5", lvl(5), 32'd0);
    pop_i     = 8'h20;
    clr_err_i = 1'b1;
    step();
    pop_i     = '0;
    clr_err_i = 1'b0;
    check("udf_clr_wins", 32'(udf_o), 32'h20);
    check("ovf_cleared",  32'(ovf_o), 32'h00);
    push_i = 8'h40;
    pop_i  = 8'h40;
    set_data(6, 24'h666666);
    step();
    push_i = '0;
    pop_i  = '0;
    check("empty_pushpop_udf",   32'(udf_o), 32'h60);
    check("empty_pushpop_level", lvl(6), 32'd1);
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    check("udf_cleared", 32'(udf_o), 32'h00);

    // Wrap on ch1: preload 10, then 200 push+pop cycles
    push_i = 8'h02;
    for (int k = 0; k < 10; k++) begin
      set_data(1, 24'h100000 + 24'(k));
      step();
    end
    pop_i = 8'h02;
    for (int k = 10; k < 210; k++) begin
      set_data(1, 24'h100000 + 24'(k));
      step();
      if (k % 40 == 0) begin
        check("wrap_tap0", dat(1), 32'h100000 + 32'(k - 10));
      end
    end
    pop_i = '0;
    check("wrap_level1", lvl(1), 32'd10);
    check("wrap_last",   dat(1), 32'h100000 + 32'd199);

    // Push lands on the tap address in the same cycle: old content returned
    set_data(1, 24'h100000 + 24'd210);
    set_off(1, 5'd10);
    step();
    push_i = '0;
    set_off(1, 5'd0);
    check("rbw_valid", 32'(valid_o[1]), 32'd0);
`ifdef RINGBUF_ZERO_FILL_EN
    check("rbw_zero", dat(1), 32'h0);
`else
    check("rbw_old",  dat(1), 32'h100000 + 32'd146);
`endif
    check("rbw_level", lvl(1), 32'd11);

    // Asynchronous reset mid-burst
    pop_i = 8'h20;
    step();
    pop_i  = '0;
    push_i = 8'h04;
    for (int i = 0; i < 3; i++) begin
      set_data(2, 24'h200000 + 24'(i));
      step();
    end
    check("pre_rst_udf",   32'(udf_o), 32'h20);
    check("pre_rst_valid", 32'(valid_o[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    push_i = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    push_i = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      set_data(0, 24'(i + 16));
      step();
    end
    push_i = '0;
    check("post_rst_level0", lvl(0), 32'd4);
    set_off(0, 5'd2);
    step();
    check("post_rst_tap2",   dat(0), 32'd19);
    check("post_rst_valid",  32'(valid_o), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
